// File: rtl/seven_seg_scan.sv
// Multiplexed common-anode seven-segment driver: per-digit dwell scan with
// double-buffered value/dp/blank, leading-zero suppression and a frame-done pulse.
module seven_seg_scan #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned DIGIT_TICKS = 200000
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic                    load,
  input  logic                    lz_suppress,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp_n,
  output logic                    frame_done
);

  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned TW = $clog2(DIGIT_TICKS);

  logic [TW-1:0]           r_tick;
  logic [IW-1:0]           r_idx;
  logic [4*NUM_DIGITS-1:0] r_pend_value;
  logic [NUM_DIGITS-1:0]   r_pend_dp;
  logic [NUM_DIGITS-1:0]   r_pend_blank;
  logic                    r_pend_valid;
  logic [4*NUM_DIGITS-1:0] r_sh_value;
  logic [NUM_DIGITS-1:0]   r_sh_dp;
  logic [NUM_DIGITS-1:0]   r_sh_blank;
  logic [NUM_DIGITS-1:0]   r_an;
  logic [6:0]              r_seg;
  logic                    r_dp_n;
  logic                    r_frame_done;

  logic                    w_tick_last;
  logic                    w_idx_last;
  logic                    w_wrap;
  logic                    w_apply;
  logic [NUM_DIGITS-1:0]   w_dark;
  logic [NUM_DIGITS-1:0]   w_an;
  logic [3:0]              w_nib;
  logic                    w_sel_dark;
  logic                    w_sel_dp;

  function automatic logic [6:0] f_seg(input logic [3:0] n);
    case (n)
      4'h0: f_seg = 7'h40;
      4'h1: f_seg = 7'h79;
      4'h2: f_seg = 7'h24;
      4'h3: f_seg = 7'h30;
      4'h4: f_seg = 7'h19;
      4'h5: f_seg = 7'h12;
      4'h6: f_seg = 7'h02;
      4'h7: f_seg = 7'h78;
      4'h8: f_seg = 7'h00;
      4'h9: f_seg = 7'h10;
      4'hA: f_seg = 7'h08;
      4'hB: f_seg = 7'h03;
      4'hC: f_seg = 7'h46;
      4'hD: f_seg = 7'h21;
      4'hE: f_seg = 7'h06;
      default: f_seg = 7'h0E;
    endcase
  endfunction

  always_comb begin : comb_decode
    logic v_zero_run;
    w_tick_last = (r_tick == TW'(DIGIT_TICKS - 1));
    w_idx_last  = (r_idx == IW'(NUM_DIGITS - 1));
    w_wrap      = en && w_tick_last && w_idx_last;
    w_apply     = r_pend_valid && (w_wrap || !en);
    // Walk from the most significant digit down so each digit knows whether
    // it and everything above it is zero.
    v_zero_run = 1'b1;
    w_dark     = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      v_zero_run = v_zero_run & (r_sh_value[4*(NUM_DIGITS-1-k) +: 4] == 4'h0);
      w_dark[NUM_DIGITS-1-k] = r_sh_blank[NUM_DIGITS-1-k] |
                               (lz_suppress & (k != NUM_DIGITS - 1) & v_zero_run);
    end
    w_nib      = '0;
    w_sel_dark = 1'b1;
    w_sel_dp   = 1'b0;
    w_an       = '1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IW'(i)) begin
        w_nib      = r_sh_value[4*i +: 4];
        w_sel_dark = w_dark[i];
        w_sel_dp   = r_sh_dp[i];
        w_an[i]    = w_dark[i];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_tick       <= '0;
      r_idx        <= '0;
      r_pend_value <= '0;
      r_pend_dp    <= '0;
      r_pend_blank <= '0;
      r_pend_valid <= 1'b0;
      r_sh_value   <= '0;
      r_sh_dp      <= '0;
      r_sh_blank   <= '1;
      r_an         <= '1;
      r_seg        <= '1;
      r_dp_n       <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      if (!en) begin
        r_tick       <= '0;
        r_idx        <= '0;
        r_an         <= '1;
        r_seg        <= '1;
        r_dp_n       <= 1'b1;
        r_frame_done <= 1'b0;
      end else begin
        if (w_tick_last) begin
          r_tick <= '0;
          r_idx  <= w_idx_last ? '0 : r_idx + IW'(1);
        end else begin
          r_tick <= r_tick + TW'(1);
        end
        r_an         <= w_an;
        r_seg        <= w_sel_dark ? 7'h7F : f_seg(w_nib);
        r_dp_n       <= w_sel_dark | ~w_sel_dp;
        r_frame_done <= w_wrap;
      end

      // A load landing on the wrap bypasses the pending buffer so it shows
      // in the frame that starts now.
      if (w_apply) begin
        r_sh_value   <= r_pend_value;
        r_sh_dp      <= r_pend_dp;
        r_sh_blank   <= r_pend_blank;
        r_pend_valid <= 1'b0;
      end
      if (load) begin
        if (w_wrap) begin
          r_sh_value   <= value;
          r_sh_dp      <= dp;
          r_sh_blank   <= blank;
          r_pend_valid <= 1'b0;
        end else begin
          r_pend_value <= value;
          r_pend_dp    <= dp;
          r_pend_blank <= blank;
          r_pend_valid <= 1'b1;
        end
      end
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign dp_n       = r_dp_n;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan (4 digits, 4-cycle dwell) with
// hand-computed per-slot expectations.
module tb_seven_seg_scan;

  localparam int unsigned ND = 4;
  localparam int unsigned DT = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic          en;
  logic [15:0]   value;
  logic [3:0]    dp;
  logic [3:0]    blank;
  logic          load;
  logic          lz_suppress;
  logic [3:0]    an;
  logic [6:0]    seg;
  logic          dp_n;
  logic          frame_done;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 CLK = ~CLK;

  seven_seg_scan #(.NUM_DIGITS(ND), .DIGIT_TICKS(DT)) dut (
    .CLK(CLK), .RST(RST), .en(en), .value(value), .dp(dp), .blank(blank),
    .load(load), .lz_suppress(lz_suppress), .an(an), .seg(seg), .dp_n(dp_n),
    .frame_done(frame_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    value = v;
    dp    = d;
    blank = b;
    load  = 1'b1;
    step();
    load  = 1'b0;
  endtask

  // Advance until frame_done is seen (bounded); leaves us just after that edge.
  task automatic wait_frame();
    int unsigned n;
    n = 0;
    step();
    while (frame_done !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check("frame_sync", {31'd0, frame_done}, 32'd1);
  endtask

  // Starting just after a frame_done edge, check all 16 cycles of the next frame.
  task automatic check_frame(input string tag, input logic [15:0] ans,
                             input logic [27:0] segs, input logic [3:0] dpns);
    int unsigned slot;
    logic [3:0] exp_an;
    for (int c = 0; c < 16; c++) begin
      step();
      slot   = c / 4;
      exp_an = ans[4*slot +: 4];
      check($sformatf("%s_an_c%0d", tag, c), {28'd0, an}, {28'd0, exp_an});
      if (exp_an != 4'hF)
        check($sformatf("%s_seg_c%0d", tag, c), {25'd0, seg}, {25'd0, segs[7*slot +: 7]});
      check($sformatf("%s_dpn_c%0d", tag, c), {31'd0, dp_n}, {31'd0, dpns[slot]});
      check($sformatf("%s_fd_c%0d", tag, c), {31'd0, frame_done}, (c == 15) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    RST = 1'b1; en = 1'b0; value = '0; dp = '0; blank = '0; load = 1'b0; lz_suppress = 1'b0;
    step();
    step();
    check("rst_an",  {28'd0, an},  32'hF);
    check("rst_seg", {25'd0, seg}, 32'h7F);
    check("rst_dpn", {31'd0, dp_n}, 32'd1);
    check("rst_fd",  {31'd0, frame_done}, 32'd0);
    RST = 1'b0;
    step();
    check("idle_an", {28'd0, an}, 32'hF);

    // Basic scan; shadow stays dark until the first wrap
    en = 1'b1;
    do_load(16'h12AF, 4'b0000, 4'b0000);
    check("predark_an", {28'd0, an}, 32'hF);
    wait_frame();
    check_frame("hex", 16'h7BDE, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'hF);
    check_frame("hex2", 16'h7BDE, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'hF);

    // Leading-zero suppression is live, load is buffered
    lz_suppress = 1'b1;
    do_load(16'h0042, 4'b0000, 4'b0000);
    wait_frame();
    check_frame("lz_on", 16'hFFDE, {7'h7F, 7'h7F, 7'h19, 7'h24}, 4'hF);
    lz_suppress = 1'b0;
    check_frame("lz_off", 16'h7BDE, {7'h40, 7'h40, 7'h19, 7'h24}, 4'hF);

    // Two loads in one frame: last wins
    do_load(16'h1111, 4'b0000, 4'b0000);
    step(); step(); step();
    do_load(16'h2222, 4'b0000, 4'b0000);
    wait_frame();
    check_frame("last_wins", 16'h7BDE, {7'h24, 7'h24, 7'h24, 7'h24}, 4'hF);

    // Load exactly on the wrap edge goes straight to shadow
    for (int k = 0; k < 15; k++) step();
    do_load(16'h3333, 4'b0000, 4'b0000);
    check("wrap_fd", {31'd0, frame_done}, 32'd1);
    check_frame("wrap_load", 16'h7BDE, {7'h30, 7'h30, 7'h30, 7'h30}, 4'hF);

    // en dropped mid-digit, then re-raised: full dwell on digit 0
    step(); step();
    en = 1'b0;
    step();
    check("en0_an",  {28'd0, an},  32'hF);
    check("en0_seg", {25'd0, seg}, 32'h7F);
    check("en0_dpn", {31'd0, dp_n}, 32'd1);
    check("en0_fd",  {31'd0, frame_done}, 32'd0);
    step(); step(); step();
    check("en0_hold_an", {28'd0, an}, 32'hF);
    en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("en1_an_k%0d", k), {28'd0, an}, (k < 4) ? 32'hE : 32'hD);
      if (k < 4) check($sformatf("en1_seg_k%0d", k), {25'd0, seg}, 32'h30);
    end
    wait_frame();

    // Decimal point and blanking
    do_load(16'h5678, 4'b0100, 4'b0001);
    wait_frame();
    check_frame("dp_blank", 16'h7BDF, {7'h12, 7'h02, 7'h78, 7'h7F}, 4'b1011);

    // Reset mid-frame after a load: pending is lost, display stays dark
    do_load(16'h9999, 4'b0000, 4'b0000);
    step(); step();
    RST = 1'b1;
    step();
    check("mrst_an",  {28'd0, an},  32'hF);
    check("mrst_seg", {25'd0, seg}, 32'h7F);
    check("mrst_dpn", {31'd0, dp_n}, 32'd1);
    check("mrst_fd",  {31'd0, frame_done}, 32'd0);
    RST = 1'b0;
    wait_frame();
    check_frame("post_rst", 16'hFFFF, {7'h7F, 7'h7F, 7'h7F, 7'h7F}, 4'hF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
